// File: rtl/noc_flit_receiver.sv
// -----------------------------------------------------------------------------
// noc_flit_receiver
//
// Far end of a credit-based router-to-endpoint flit link. Incoming flits are
// written into a small circular FIFO and presented downstream as a single-flit
// AXI-stream master. Each flit drained downstream returns one credit to the
// sender one cycle later, so the sender's credit counter (initialised to
// BUFFER_DEPTH) never lets it overrun the buffer in normal operation.
//
// A two-state tracker follows packet boundaries on the popped stream. It
// counts completed packets (tails popped) and reports whether a packet is
// partially drained.
//
// Optional feature (macro NOC_FLIT_RECEIVER_OVERFLOW_CHECK_EN):
//   defined   - a flit arriving while the buffer is full with no pop in the
//               same cycle sets the sticky err_overflow flag, and a
//               simulation-only assertion reports it.
//   undefined - err_overflow is tied low and no check logic is built.
// In both builds such a flit is dropped and no pointer moves.
// -----------------------------------------------------------------------------
module noc_flit_receiver #(
    parameter int FLIT_WIDTH   = 64,
    parameter int DEST_WIDTH   = 4,
    parameter int BUFFER_DEPTH = 2,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                                  clk_noc,
    input  logic                                  rst_n,

    // Router-side flit link
    input  logic [FLIT_WIDTH-1:0]                 data_in,
    input  logic [DEST_WIDTH-1:0]                 dest_in,
    input  logic                                  is_tail_in,
    input  logic                                  send_in,
    output logic                                  credit_out,

    // AXI-stream master
    output logic                                  axis_tvalid,
    input  logic                                  axis_tready,
    output logic [FLIT_WIDTH-1:0]                 axis_tdata,
    output logic [DEST_WIDTH-1:0]                 axis_tdest,
    output logic                                  axis_tlast,

    // Status
    output logic [$clog2(BUFFER_DEPTH+1)-1:0]     occupancy,
    output logic                                  in_packet,
    output logic [CNT_WIDTH-1:0]                  pkt_count,
    output logic                                  err_overflow
);

    // -------------------------------------------------------------------------
    // Local types and constants
    // -------------------------------------------------------------------------
    localparam int OCC_W = $clog2(BUFFER_DEPTH + 1);
    localparam int PTR_W = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [OCC_W-1:0] occ_t;

    typedef struct packed {
        logic [FLIT_WIDTH-1:0] data;
        logic [DEST_WIDTH-1:0] dest;
        logic                  tail;
    } flit_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_IN_PKT = 1'b1
    } pkt_state_e;

    // Pointers wrap explicitly at BUFFER_DEPTH-1, so non-power-of-two depths
    // work. Full/empty come from the occupancy counter, not from pointer
    // equality, so full can never look like empty.
    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == PTR_W'(BUFFER_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    flit_t          mem_q [BUFFER_DEPTH];
    ptr_t           wr_ptr_q,   wr_ptr_d;
    ptr_t           rd_ptr_q,   rd_ptr_d;
    occ_t           occ_q,      occ_d;
    logic           credit_q,   credit_d;
    pkt_state_e     state_q,    state_d;
    logic [CNT_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d;

    // -------------------------------------------------------------------------
    // Handshake decode
    // -------------------------------------------------------------------------
    logic  empty;
    logic  full;
    logic  pop;
    logic  push;
    flit_t flit_in;
    flit_t head;

    assign empty   = (occ_q == '0);
    assign full    = (occ_q == OCC_W'(BUFFER_DEPTH));
    assign pop     = axis_tvalid & axis_tready;
    // A flit arriving on a full buffer still fits when the head leaves in
    // the same cycle.
    assign push    = send_in & (~full | pop);
    assign flit_in = '{data: data_in, dest: dest_in, tail: is_tail_in};

    // The head always comes from storage. A flit written this cycle becomes
    // visible on the next cycle and is never bypassed from the input.
    assign head        = mem_q[rd_ptr_q];
    assign axis_tvalid = ~empty;
    assign axis_tdata  = head.data;
    assign axis_tdest  = head.dest;
    assign axis_tlast  = head.tail;

    assign occupancy  = occ_q;
    assign credit_out = credit_q;
    assign in_packet  = (state_q == ST_IN_PKT);
    assign pkt_count  = pkt_cnt_q;

    // -------------------------------------------------------------------------
    // Flit storage write port
    // -------------------------------------------------------------------------
    // NOTE: the storage array has no reset. Valid entries are tracked only by
    // the pointers and the occupancy counter, so resetting the data would add
    // a reset fan-out to every storage bit and buy nothing.
    always_ff @(posedge clk_noc) begin
        if (push) begin
            mem_q[wr_ptr_q] <= flit_in;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic for pointers, occupancy and the credit return
    // -------------------------------------------------------------------------
    // NOTE: every signal assigned here gets a default value first. Without
    // the defaults, a path that skips the assignment would infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        credit_d = pop;

        if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        unique case ({push, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;  // idle, or push and pop together
        endcase
    end

    // -------------------------------------------------------------------------
    // Next-state logic for packet tracking and the completed-packet count
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        pkt_cnt_d = pkt_cnt_q;

        if (pop) begin
            if (axis_tlast) begin
                // A tail closes the packet. A single-flit packet is counted
                // from IDLE and never enters IN_PKT.
                state_d   = ST_IDLE;
                pkt_cnt_d = pkt_cnt_q + CNT_WIDTH'(1);  // wraps naturally
            end else begin
                state_d   = ST_IN_PKT;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Control register bank
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples its pre-edge inputs and the result does not depend on the order
    // in which the simulator evaluates the blocks.
    always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            occ_q     <= '0;
            credit_q  <= 1'b0;
            state_q   <= ST_IDLE;
            pkt_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            occ_q     <= occ_d;
            credit_q  <= credit_d;
            state_q   <= state_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

`ifdef NOC_FLIT_RECEIVER_OVERFLOW_CHECK_EN
    // -------------------------------------------------------------------------
    // Overflow detection: a flit that reaches a full buffer with no pop in the
    // same cycle means the sender broke the credit protocol.
    // -------------------------------------------------------------------------
    logic overflow_evt;
    logic err_ovf_q, err_ovf_d;

    assign overflow_evt = send_in & full & ~pop;
    assign err_overflow = err_ovf_q;

    // Sticky error flag; only reset clears it.
    always_comb begin
        err_ovf_d = err_ovf_q | overflow_evt;
    end

    // Error flag register
    always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
            err_ovf_q <= 1'b0;
        end else begin
            err_ovf_q <= err_ovf_d;
        end
    end

`ifndef SYNTHESIS
    // Report a protocol violation by the sender as it happens.
    always @(posedge clk_noc) begin
        if (rst_n) begin
            assert (!overflow_evt)
                else $warning("noc_flit_receiver: flit dropped, buffer full without pop");
        end
    end
`endif
`else
    // No overflow checking in this build. Overflow flits are still dropped.
    assign err_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_noc_flit_receiver.sv
// -----------------------------------------------------------------------------
// tb_noc_flit_receiver
//
// Self-checking bench for noc_flit_receiver (BUFFER_DEPTH=2, CNT_WIDTH=4).
// The reference model is a queue of flits plus a few integers: the pending
// credit, the completed-packet total and the "mid-packet" flag. It is advanced
// once per clock from the link rules. The bench runs directed scenarios first,
// then randomized traffic.
// -----------------------------------------------------------------------------
module tb_noc_flit_receiver;

    localparam int FW    = 64;
    localparam int DW    = 4;
    localparam int DEPTH = 2;
    localparam int CW    = 4;
    localparam int OW    = $clog2(DEPTH + 1);

`ifdef NOC_FLIT_RECEIVER_OVERFLOW_CHECK_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic            clk_noc = 1'b0;
    logic            rst_n;
    logic [FW-1:0]   data_in;
    logic [DW-1:0]   dest_in;
    logic            is_tail_in;
    logic            send_in;
    logic            credit_out;
    logic            axis_tvalid;
    logic            axis_tready;
    logic [FW-1:0]   axis_tdata;
    logic [DW-1:0]   axis_tdest;
    logic            axis_tlast;
    logic [OW-1:0]   occupancy;
    logic            in_packet;
    logic [CW-1:0]   pkt_count;
    logic            err_overflow;

    noc_flit_receiver #(
        .FLIT_WIDTH  (FW),
        .DEST_WIDTH  (DW),
        .BUFFER_DEPTH(DEPTH),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk_noc     (clk_noc),
        .rst_n       (rst_n),
        .data_in     (data_in),
        .dest_in     (dest_in),
        .is_tail_in  (is_tail_in),
        .send_in     (send_in),
        .credit_out  (credit_out),
        .axis_tvalid (axis_tvalid),
        .axis_tready (axis_tready),
        .axis_tdata  (axis_tdata),
        .axis_tdest  (axis_tdest),
        .axis_tlast  (axis_tlast),
        .occupancy   (occupancy),
        .in_packet   (in_packet),
        .pkt_count   (pkt_count),
        .err_overflow(err_overflow)
    );

    always #5 clk_noc = ~clk_noc;

    // ---------------------------------------------------------------------
    // Reference model state
    // ---------------------------------------------------------------------
    typedef struct {
        logic [FW-1:0] data;
        logic [DW-1:0] dest;
        logic          tail;
    } flit_t;

    flit_t model_q[$];
    bit    credit_m;
    bit    in_pkt_m;
    int    pkt_m;
    bit    err_m;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        model_q.delete();
        credit_m = 1'b0;
        in_pkt_m = 1'b0;
        pkt_m    = 0;
        err_m    = 1'b0;
    endtask

    // Compare every visible output against the model.
    task automatic check_outputs();
        check("tvalid", axis_tvalid, model_q.size() > 0);
        if (model_q.size() > 0) begin
            check("tdata", axis_tdata, model_q[0].data);
            check("tdest", axis_tdest, model_q[0].dest);
            check("tlast", axis_tlast, model_q[0].tail);
        end
        check("occupancy",    occupancy,    model_q.size());
        check("credit_out",   credit_out,   credit_m);
        check("in_packet",    in_packet,    in_pkt_m);
        check("pkt_count",    pkt_count,    pkt_m % (1 << CW));
        check("err_overflow", err_overflow, err_m);
    endtask

    // One clock: check the current outputs, drive the inputs, advance the
    // model to the state after the next rising edge, then wait for that edge.
    task automatic step(input bit s, input logic [FW-1:0] d, input logic [DW-1:0] de,
                        input bit t, input bit r);
        bit    pop;
        bit    full;
        flit_t f;
        check_outputs();
        send_in     = s;
        data_in     = d;
        dest_in     = de;
        is_tail_in  = t;
        axis_tready = r;

        pop  = (model_q.size() > 0) && r;
        full = (model_q.size() == DEPTH);
        if (s && full && !pop) err_m = err_m | OVF_EN;
        credit_m = pop;
        if (pop) begin
            f = model_q.pop_front();
            if (f.tail) begin
                pkt_m++;
                in_pkt_m = 1'b0;
            end else begin
                in_pkt_m = 1'b1;
            end
        end
        if (s && (!full || pop)) begin
            f.data = d;
            f.dest = de;
            f.tail = t;
            model_q.push_back(f);
        end
        @(posedge clk_noc);
        @(negedge clk_noc);
    endtask

    task automatic idle(input int n, input bit r);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, r);
    endtask

    // Reset at a negedge with the clock running, then release.
    task automatic do_reset();
        rst_n       = 1'b0;
        send_in     = 1'b0;
        axis_tready = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk_noc);
        @(negedge clk_noc);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n       = 1'b0;
        data_in     = '0;
        dest_in     = '0;
        is_tail_in  = 1'b0;
        send_in     = 1'b0;
        axis_tready = 1'b0;
        model_reset();
        @(negedge clk_noc);
        do_reset();

        // Single tail flit: visible next cycle, pop, then one credit.
        step(1'b1, 64'hA5, 4'd3, 1'b1, 1'b1);
        check("single_valid", axis_tvalid, 1'b1);
        check("single_data",  axis_tdata, 64'hA5);
        step(1'b0, '0, '0, 1'b0, 1'b1);
        check("single_credit", credit_out, 1'b1);
        check("single_pkt",    pkt_count, 4'd1);
        idle(2, 1'b1);

        // Four-flit packet streamed with tready held high.
        for (int i = 0; i < 4; i++) step(1'b1, 64'h100 + 64'(i), 4'(i), i == 3, 1'b1);
        idle(3, 1'b1);
        check("pkt4_count", pkt_count, 4'd2);

        // Back-pressure: fill the buffer, then drain it.
        step(1'b1, 64'hB0, 4'd1, 1'b0, 1'b0);
        step(1'b1, 64'hB1, 4'd2, 1'b1, 1'b0);
        check("full_occ", occupancy, 2'd2);
        idle(2, 1'b0);
        idle(3, 1'b1);

        // Full with a push and a pop every cycle, crossing the pointer wrap.
        step(1'b1, 64'hC0, 4'd5, 1'b1, 1'b0);
        step(1'b1, 64'hC1, 4'd6, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 64'hC2 + 64'(i), 4'(i), 1'b1, 1'b1);
        check("stream_occ", occupancy, 2'd2);
        idle(3, 1'b1);

        // Overflow: full with no pop. The flit is dropped.
        step(1'b1, 64'hD0, 4'd7, 1'b1, 1'b0);
        step(1'b1, 64'hD1, 4'd8, 1'b1, 1'b0);
        step(1'b1, 64'hDEAD, 4'd9, 1'b1, 1'b0);
        check("ovf_flag", err_overflow, OVF_EN);
        idle(4, 1'b1);
        check("ovf_sticky", err_overflow, OVF_EN);

        // Reset with one flit buffered and a credit pending.
        step(1'b1, 64'hE0, 4'd1, 1'b1, 1'b0);
        step(1'b1, 64'hE1, 4'd2, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b1);   // pops one flit; credit now pending
        check("pre_rst_occ", occupancy, 2'd1);
        do_reset();
        idle(3, 1'b1);
        check("post_rst_credit", credit_out, 1'b0);

        // Seventeen single-flit packets: the 4-bit count wraps to 1.
        for (int i = 0; i < 17; i++) step(1'b1, 64'(i), 4'(i), 1'b1, 1'b1);
        idle(2, 1'b1);
        check("wrap_count", pkt_count, 4'd1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0, {$urandom, $urandom}, 4'($urandom),
                 $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0);
        end
        idle(4, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/noc_flit_receiver.md
# noc_flit_receiver

Receiving endpoint of the router's credit-based flit link: it accepts flits driven by a router output port (`data`/`dest`/`is_tail`/`send`), buffers them, and presents them as a single-flit AXI-stream master. It returns one credit per flit drained downstream. It sits at the far end of any router-to-endpoint link in the `clk_noc` domain, matching the router output port's credit counter initialised to `BUFFER_DEPTH`.

## Interface
Parameters:
- `FLIT_WIDTH`, 64, flit payload width.
- `DEST_WIDTH`, 4, destination field width (`{tid, tdest}`).
- `BUFFER_DEPTH`, 2, flit buffer entries; must be ≥1. Equals the sender's initial credit count.
- `CNT_WIDTH`, 16, width of the completed-packet counter.

Ports:
- `clk_noc` in 1: single clock; all logic is on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `data_in` in `FLIT_WIDTH`: flit payload.
- `dest_in` in `DEST_WIDTH`: flit destination.
- `is_tail_in` in 1: last flit of a packet.
- `send_in` in 1: flit valid this cycle.
- `credit_out` out 1: one-cycle pulse returning one credit.
- `axis_tvalid` out 1: output flit valid.
- `axis_tready` in 1: downstream accept.
- `axis_tdata` out `FLIT_WIDTH`: output payload.
- `axis_tdest` out `DEST_WIDTH`: output destination.
- `axis_tlast` out 1: equals the stored `is_tail`.
- `occupancy` out `$clog2(BUFFER_DEPTH+1)`: entries held.
- `in_packet` out 1: a non-tail flit has been popped and its tail has not.
- `pkt_count` out `CNT_WIDTH`: tails popped, modulo 2^`CNT_WIDTH`.
- `err_overflow` out 1: sticky flag for a flit arriving while the buffer was full.

## Operation
- The buffer is a circular FIFO with read/write pointers mod `BUFFER_DEPTH` and an occupancy counter. No `BUFFER_DEPTH` value, power of two or not, may alias full with empty.
- Push: `send_in=1` writes `{data_in, dest_in, is_tail_in}` at the write pointer. It is accepted if not full, or if full with a pop in the same cycle.
- Pop: occurs when `axis_tvalid & axis_tready`. The head is driven directly from buffer storage; it is not combinationally bypassed from the input.
- Credit: every pop causes `credit_out=1` on the following cycle, exactly one pulse per pop. Back-to-back pops give back-to-back pulses. No initial credits are emitted after reset.
- Packet tracking uses two states:
  - IDLE (reset state): a pop with `axis_tlast=0` goes to IN_PKT. A pop with `axis_tlast=1` stays in IDLE and increments `pkt_count`.
  - IN_PKT: a pop with `axis_tlast=1` goes to IDLE and increments `pkt_count`. Otherwise it stays in IN_PKT.
  - `in_packet` is 1 in IN_PKT.
- `pkt_count` wraps from all-ones to 0.
- Boundary cases:
  - Empty: `axis_tvalid=0`; `axis_tready` is ignored.
  - Full without a pop: the incoming flit is dropped and no pointer moves (see Configuration).
  - Simultaneous push and pop at any occupancy: occupancy is unchanged and both pointers advance.
  - Single-flit packet (head = tail): counted once and no IN_PKT visit.

## Timing
- Latency from `send_in` to `axis_tvalid` is 1 cycle. A flit written in cycle N is visible in cycle N+1 when the buffer was empty.
- Latency from pop to `credit_out` is 1 cycle, registered.
- Throughput: 1 flit/cycle sustained with `axis_tready=1` and `BUFFER_DEPTH≥1`.
- `occupancy`, `in_packet` and `pkt_count` update on the edge after the event.
- AXI rules: once `axis_tvalid` is asserted, it and `axis_tdata`/`axis_tdest`/`axis_tlast` hold until a pop.
- Reset values: `axis_tvalid=0`, `credit_out=0`, `occupancy=0`, `in_packet=0`, `pkt_count=0`, `err_overflow=0`, pointers 0, state IDLE. `axis_tdata`/`axis_tdest`/`axis_tlast` are don't-care while `axis_tvalid=0`.
- Reset mid-operation: buffer contents are discarded, no pending `credit_out` pulse is emitted, and the sender must also be reset.

## Configuration
- Macro `NOC_FLIT_RECEIVER_OVERFLOW_CHECK_EN`.
- Defined: a push while full without a pop sets `err_overflow`, sticky until reset. A simulation-only assertion also fires.
- Undefined: `err_overflow` is tied to 0, no check logic is built, and overflow flits are still dropped silently.

## Test plan
- Reset then a single tail flit (`data=0xA5`, `dest=3`) → `axis_tvalid` high next cycle. With `tready=1`: pop, `credit_out` pulses 1 cycle later, `pkt_count=1`, `in_packet=0`.
- 4-flit packet with `tready=1` → 4 pops, 4 credit pulses on consecutive cycles. `in_packet` is high after pop 1 through pop 3 and drops after the tail pop. `pkt_count` +1.
- `tready=0`, 2 flits sent (`BUFFER_DEPTH=2`) → `occupancy=2`, no credits. Then `tready=1` → 2 pops and 2 pulses, in order.
- Full buffer with simultaneous `send_in` and pop → occupancy stays 2, no overflow, FIFO order preserved across pointer wrap.
- Macro defined, full buffer, `send_in` without pop → flit dropped, `err_overflow=1` and holds until `rst_n=0`.
- `CNT_WIDTH=4`, 17 single-flit packets → `pkt_count` wraps to 1. `rst_n` asserted with 1 flit buffered → all outputs return to reset values and no `credit_out` pulse follows.
